// File: rtl/data_reg_arbiter.sv
// Round-robin arbiter feeding one registered data stage; a winner keeps the
// grant for its whole burst and the captured beat is offered downstream with valid/ready.
module data_reg_arbiter #(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = 8,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   input  logic [N_REQ-1:0]        i_req_last,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_data,
   output logic [ID_W-1:0]         o_grant_id,
   output logic                    o_last,
   input  logic                    i_ready,
   output logic                    o_locked
);

   typedef enum logic {
      ST_ARB,
      ST_LOCKED
   } state_t;

   state_t              state, state_next;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     lock_id;
   logic                slot_free;
   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [ID_W:0]       scan_idx;
   logic [ID_W-1:0]     acc_id;
   logic                accept;
   logic [DATA_W-1:0]   acc_data;
   logic                acc_last;
   logic [ID_W-1:0]     ptr_after;

   assign slot_free = !o_valid || i_ready;
   assign o_locked  = (state == ST_LOCKED);

   // Scan for the first valid requester starting at ptr, wrapping past N_REQ-1.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (scan_idx >= (ID_W+1)'(N_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(N_REQ);
         end
         if (!win_found && i_req_valid[scan_idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   assign acc_id = (state == ST_LOCKED) ? lock_id : win_id;
   assign accept = |(i_req_valid & o_req_ready);

   always_comb begin
      acc_data = '0;
      acc_last = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (acc_id == ID_W'(k)) begin
            acc_data = i_req_data[k*DATA_W +: DATA_W];
            acc_last = i_req_last[k];
         end
      end
   end

   assign ptr_after = (acc_id == ID_W'(N_REQ-1)) ? '0 : acc_id + ID_W'(1);

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state <= ST_ARB;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: every accepted beat decides whether the burst continues.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = acc_last ? ST_ARB : ST_LOCKED;
      end
   end

   // Output logic: ready is withheld entirely while reset is asserted.
   always_comb begin
      o_req_ready = '0;
      if (i_reset_n) begin
         case (state)
            ST_ARB: begin
               if (slot_free && win_found) begin
                  o_req_ready[win_id] = 1'b1;
               end
            end
            ST_LOCKED: begin
               o_req_ready[lock_id] = slot_free;
            end
            default: o_req_ready = '0;
         endcase
      end
   end

   // Output data stage plus arbitration pointer and lock owner.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_grant_id <= '0;
         o_last     <= 1'b0;
         ptr        <= '0;
         lock_id    <= '0;
      end else if (accept) begin
         o_valid    <= 1'b1;
         o_data     <= acc_data;
         o_grant_id <= acc_id;
         o_last     <= acc_last;
         if (acc_last) begin
            ptr <= ptr_after;
         end else begin
            lock_id <= acc_id;
         end
      end else if (slot_free) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_reg_arbiter.sv
// Self-checking bench for data_reg_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural arbiter model.
module tb_data_reg_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = $clog2(N);

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_id;
   logic            out_last;
   logic            ready_in;
   logic            locked;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   int   m_ptr;
   bit   m_locked;
   int   m_lock;
   bit   m_valid;
   int   m_data;
   int   m_id;
   bit   m_last;

   data_reg_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .i_req_last  (req_last),
      .o_req_ready (req_ready),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_grant_id  (out_id),
      .o_last      (out_last),
      .i_ready     (ready_in),
      .o_locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_ptr    = 0;
      m_locked = 0;
      m_lock   = 0;
      m_valid  = 0;
      m_data   = 0;
      m_id     = 0;
      m_last   = 0;
   endfunction

   function automatic logic [N-1:0] model_ready();
      bit free;
      int k;
      free = !m_valid || ready_in;
      if (!rst_n) return '0;
      if (m_locked) return free ? N'(1 << m_lock) : '0;
      if (!free) return '0;
      for (int i = 0; i < N; i++) begin
         k = (m_ptr + i) % N;
         if (req_valid[k]) return N'(1 << k);
      end
      return '0;
   endfunction

   function automatic void model_step(input logic [N-1:0] rdy);
      logic [N-1:0] acc;
      bit free;
      free = !m_valid || ready_in;
      acc  = rdy & req_valid;
      if (acc != '0) begin
         for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
               m_valid = 1;
               m_data  = int'(req_data[k*DW +: DW]);
               m_id    = k;
               m_last  = req_last[k];
               if (req_last[k]) begin
                  m_ptr    = (k + 1) % N;
                  m_locked = 0;
               end else begin
                  m_locked = 1;
                  m_lock   = k;
               end
            end
         end
      end else if (free) begin
         m_valid = 0;
      end
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input string tag);
      logic [N-1:0] er;
      #1;
      er = model_ready();
      check({tag, " ready"},  32'(req_ready), 32'(er));
      check({tag, " valid"},  32'(out_valid), 32'(m_valid));
      check({tag, " data"},   32'(out_data),  32'(m_data));
      check({tag, " id"},     32'(out_id),    32'(m_id));
      check({tag, " last"},   32'(out_last),  32'(m_last));
      check({tag, " locked"}, 32'(locked),    32'(m_locked));
      @(posedge clk);
      model_step(er);
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic [DW-1:0] d, input logic l);
      req_data[k*DW +: DW] = d;
      req_last[k]          = l;
   endtask

   // Asynchronous reset asserted mid-cycle with every requester valid.
   task automatic do_reset(input string tag);
      req_valid = '1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, " rst valid"},  32'(out_valid), 32'd0);
      check({tag, " rst data"},   32'(out_data),  32'd0);
      check({tag, " rst id"},     32'(out_id),    32'd0);
      check({tag, " rst last"},   32'(out_last),  32'd0);
      check({tag, " rst locked"}, 32'(locked),    32'd0);
      check({tag, " rst ready"},  32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      ready_in  = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_reset("reset");

      // Single beat from requester 2.
      req_valid = 4'b0100;
      set_req(2, 8'hA5, 1'b1);
      #1;
      check("single ready", 32'(req_ready), 32'b0100);
      cycle("single");
      check("single out data", 32'(out_data),  32'hA5);
      check("single out id",   32'(out_id),    32'd2);
      check("single out last", 32'(out_last),  32'd1);
      check("single out vld",  32'(out_valid), 32'd1);

      // Round-robin with everyone valid and single-beat bursts.
      do_reset("rr");
      req_valid = 4'b1111;
      for (int k = 0; k < N; k++) set_req(k, 8'(8'h10 + k), 1'b1);
      for (int n = 0; n < 6; n++) begin
         cycle("rr");
         check("rr order id",   32'(out_id),    32'(n % N));
         check("rr order data", 32'(out_data),  32'(8'h10 + (n % N)));
         check("rr no bubble",  32'(out_valid), 32'd1);
      end

      // Burst lock on requester 1 while requester 0 stays valid.
      do_reset("burst");
      req_valid = 4'b0001;
      set_req(0, 8'h01, 1'b1);
      cycle("burst pre");
      req_valid = 4'b0011;
      set_req(0, 8'h77, 1'b1);
      set_req(1, 8'h11, 1'b0);
      cycle("burst b1");
      check("burst b1 data", 32'(out_data), 32'h11);
      check("burst b1 lock", 32'(locked),   32'd1);
      set_req(1, 8'h22, 1'b0);
      cycle("burst b2");
      check("burst b2 data", 32'(out_data), 32'h22);
      check("burst b2 lock", 32'(locked),   32'd1);
      set_req(1, 8'h33, 1'b1);
      cycle("burst b3");
      check("burst b3 data", 32'(out_data), 32'h33);
      check("burst b3 id",   32'(out_id),   32'd1);
      check("burst b3 lock", 32'(locked),   32'd0);
      req_valid = 4'b0001;
      cycle("burst next");
      check("burst next id",   32'(out_id),   32'd0);
      check("burst next data", 32'(out_data), 32'h77);

      // Backpressure holds the output and blocks all requesters.
      set_req(0, 8'h5C, 1'b1);
      cycle("bp load");
      check("bp load data", 32'(out_data), 32'h5C);
      ready_in  = 1'b0;
      req_valid = 4'b0010;
      set_req(1, 8'h66, 1'b1);
      for (int n = 0; n < 3; n++) begin
         cycle("bp hold");
         check("bp hold data",  32'(out_data),  32'h5C);
         check("bp hold ready", 32'(req_ready), 32'd0);
      end
      ready_in = 1'b1;
      #1;
      check("bp release ready", 32'(req_ready), 32'b0010);
      cycle("bp release");
      check("bp release data", 32'(out_data), 32'h66);

      // Reset in the middle of a burst from requester 3.
      req_valid = 4'b1000;
      set_req(3, 8'hC1, 1'b0);
      cycle("midrst b1");
      set_req(3, 8'hC2, 1'b0);
      cycle("midrst b2");
      check("midrst locked", 32'(locked), 32'd1);
      do_reset("midrst");
      req_valid = 4'b1001;
      set_req(0, 8'h0A, 1'b1);
      set_req(3, 8'h3A, 1'b1);
      #1;
      check("midrst ready", 32'(req_ready), 32'b0001);
      cycle("midrst after");
      check("midrst after id", 32'(out_id), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < N; k++) begin
            req_valid[k] = ($urandom_range(0, 3) != 0);
            set_req(k, 8'($urandom), ($urandom_range(0, 2) == 0));
         end
         ready_in = ($urandom_range(0, 3) != 0);
         if (n == 300) do_reset("rand");
         else cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_reg_arbiter.md
# data_reg_arbiter

Round-robin arbiter that shares one registered 8-bit data stage between `N_REQ` requesters. Each requester uses a valid/ready handshake. Once a requester wins, it keeps the grant for a multi-beat burst until it presents a beat with `last` set. The winning beat is captured into a single output register, which is presented downstream with valid/ready flow control. The block sits in front of the register datapath and sequences all writes into it.

## Interface
- `N_REQ`, 4, number of requesters; legal range 2..16, need not be a power of two.
- `DATA_W`, 8, data width per beat.
- `ID_W`, `$clog2(N_REQ)`, width of the grant id (localparam).

- `i_clk`  in  1  single clock; all state on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  N_REQ  per-requester beat valid.
- `i_req_data`  in  N_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W].
- `i_req_last`  in  N_REQ  marks the final beat of requester k's burst.
- `o_req_ready`  out  N_REQ  one-hot or zero; beat k is accepted when `i_req_valid[k] && o_req_ready[k]`.
- `o_valid`  out  1  output register holds a beat.
- `o_data`  out  DATA_W  captured beat data.
- `o_grant_id`  out  ID_W  index of the requester that supplied `o_data`.
- `o_last`  out  1  captured `last` flag.
- `i_ready`  in  1  downstream accepts the beat when `o_valid && i_ready`.
- `o_locked`  out  1  arbiter is inside a burst (state LOCKED).

## Operation
- **Slot free** is defined as `!o_valid || i_ready`. No beat is accepted while the slot is not free.
- **State ARB:**
  - Only entered or held when no burst is in progress.
  - If the slot is free and any `i_req_valid` is set, the winner `w` is the first set index scanning from `ptr` upward, wrapping from N_REQ-1 to 0.
  - `o_req_ready[w]=1`; all other ready bits are 0.
- **State LOCKED on `lock_id`:**
  - `o_req_ready[lock_id] = slot free`.
  - Other requesters are ignored regardless of their valid.
- **On acceptance of beat from requester `w`:**
  - `o_data <= data[w]`, `o_grant_id <= w`, `o_last <= last[w]`, `o_valid <= 1`.
  - If `last[w]=1`: `ptr <= (w+1) mod N_REQ`, next state is ARB.
  - If `last[w]=0`: `lock_id <= w`, next state is LOCKED.
- **Slot free with no acceptance:** `o_valid <= 0`. `o_data`, `o_grant_id` and `o_last` hold their last values.
- **Locked requester drops valid mid-burst:** the arbiter stays LOCKED and waits indefinitely. There is no timeout.
- **Reset (asynchronous, immediate when `i_reset_n` falls):**
  - Registers: `o_valid=0`, `o_data=0`, `o_grant_id=0`, `o_last=0`, `o_locked=0`, `ptr=0`, state ARB.
  - `o_req_ready` is forced to all-zero while `i_reset_n` is low.
  - Reset mid-burst abandons the burst; no beat is emitted.
- `o_locked` is 1 exactly when the state is LOCKED.

## Timing
- **Accept-to-output latency:** 1 cycle. A beat accepted at edge n appears on `o_valid`/`o_data` after edge n.
- **Throughput:** 1 beat per cycle while `i_ready=1` and a requester is valid.
- **Combinational paths:** `o_req_ready` depends on `i_req_valid`, `i_ready`, state, `ptr` and `o_valid`. This path is documented and accepted. `i_ready` low with `o_valid=1` forces all ready bits to 0 in the same cycle.
- **Output stability:** `o_data`, `o_grant_id` and `o_last` are stable while `o_valid && !i_ready`.
- **Same-cycle hand-over:** a downstream transfer and a new acceptance in the same cycle load the new beat with no bubble.
- **Grant hand-over after a burst:** takes effect in the cycle after the `last` beat is accepted. There is no idle cycle if another requester is valid.
- **Fairness:** a requester continuously asserting valid is granted within N_REQ-1 bursts of other requesters.

## Test plan
- **Reset:** assert `i_reset_n=0` asynchronously mid-cycle with all valid bits high -> immediately `o_valid=0`, `o_data=0x00`, `o_grant_id=0`, `o_locked=0`, `o_req_ready=0000`.
- **Single beat:** req2 valid with data 0xA5, last=1, `i_ready=1` -> `o_req_ready=0100` in the same cycle. Next cycle: `o_valid=1`, `o_data=0xA5`, `o_grant_id=2`, `o_last=1`.
- **Round-robin order:** all four requesters continuously valid with single-beat bursts (data = 0x10+k), `i_ready=1` -> output ids 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- **Burst lock:** req1 sends 0x11, 0x22, 0x33 (last on 0x33) while req0 is also valid -> outputs 0x11, 0x22, 0x33 with id 1 and `o_locked=1` during the first two beats. Then req0's beat follows immediately; `ptr` wraps so req0 wins over req3-absent slots.
- **Backpressure:** `o_valid=1` with `o_data=0x5C` and `i_ready=0` for 3 cycles -> `o_data` stays 0x5C and `o_req_ready=0000`. When `i_ready` returns to 1, the next pending beat is accepted in that same cycle and appears on the following cycle.
- **Reset mid-burst:** req3 burst with 2 of 4 beats sent, then pulse `i_reset_n` low -> `o_locked=0`, `o_valid=0`. After release, req0 and req3 both valid -> req0 is granted first (`ptr=0`).
